// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding req/ack
// fetch to instruction memory, buffers words in a prefetch FIFO, handles redirects and halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        npc_control,
  input  logic [31:0] branch_pc,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        halt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             req_q, req_d;
  logic             stale_q, stale_d;
  logic             halt_q, halt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic        redirect, acked, push, pop, issue, valid_w;
  logic [31:0] head_pc, head_instr;

  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_instr = instr_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    stale_d    = stale_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    // Redirect outranks dequeue, push and issue; it is ignored once halted.
    redirect = npc_control && !halt_q;
    acked    = req_q && imem_ack;
    valid_w  = (count_q != '0) && !halt_q;
    pop      = valid_w && ready && !redirect;
    push     = acked && !stale_q && !redirect && !halt_q;
    halt_d   = halt_q || (pop && (head_instr == HALT_INSTR));

    if (redirect) begin
      fetch_pc_d = branch_pc & ~32'h3;
      stale_d    = req_q && !imem_ack;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (acked) stale_d = 1'b0;
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Issuing against the post-update occupancy guarantees a free slot when the ack returns.
    issue = (!req_q || imem_ack) && !halt_d && !npc_control && (count_d < DEPTH_C);
    req_d = issue || (req_q && !imem_ack);
    if (issue) req_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rstn) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      stale_q    <= 1'b0;
      halt_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      stale_q    <= stale_d;
      halt_q     <= halt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only observed through count, which is.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = req_addr_q;
  assign valid       = valid_w;
  assign instruction = valid_w ? head_instr : NOP_INSTR;
  assign PC          = valid_w ? head_pc : 32'h0;
  assign halt        = halt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver models memory and the expected FIFO contents,
// a separate monitor pops expected entries whenever decode takes one.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] HALT_W   = 32'h0000_0073;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        npc_control = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic        halt;

  fetch_unit #(
    .RESET_PC(RESET_PC), .DEPTH(DEPTH), .HALT_INSTR(HALT_W), .NOP_INSTR(NOP_W)
  ) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .npc_control(npc_control), .branch_pc(branch_pc),
    .ready(ready), .valid(valid), .instruction(instruction), .PC(PC), .halt(halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  entry_t      exp_q[$];
  logic        pending = 1'b0;
  logic        live = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] next_addr = RESET_PC;
  logic        mhalt = 1'b0;
  logic        h_before = 1'b0;
  logic        mon_en = 1'b0;

  int ack_pct = 100, ready_pct = 100, npc_pct = 0;
  logic junk_ack = 1'b0;
  logic halt_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && a == 32'h10) return HALT_W;
    return {a[29:0], 2'b10};
  endfunction

  task automatic choose_inputs();
    h_before = mhalt;
    if (pending) imem_ack = ($urandom_range(99) < ack_pct);
    else         imem_ack = junk_ack && ($urandom_range(99) < 10);
    imem_rdata  = pending ? mem_word(pend_addr) : $urandom();
    ready       = ($urandom_range(99) < ready_pct);
    npc_control = ($urandom_range(99) < npc_pct);
    branch_pc   = {$urandom_range(255), 2'b00} | 32'($urandom_range(3));
  endtask

  // Applies the spec rules for the edge that just passed, then checks the request side.
  task automatic update_model();
    logic redir;
    logic exp_req;
    redir = npc_control && !h_before;
    if (pending && imem_ack) begin
      pending = 1'b0;
      if (live && !redir && !h_before) begin
        exp_q.push_back('{pc: pend_addr, instr: imem_rdata});
        next_addr = next_addr + 32'd4;
      end
    end
    if (redir) begin
      exp_q.delete();
      next_addr = {branch_pc[31:2], 2'b00};
      if (pending) live = 1'b0;
    end
    exp_req = pending || (!mhalt && !npc_control && exp_q.size() < DEPTH);
    check("imem_req", imem_req, exp_req);
    if (imem_req) begin
      if (!pending) begin
        check("imem_addr_new", imem_addr, next_addr);
        pending   = 1'b1;
        live      = 1'b1;
        pend_addr = next_addr;
      end else begin
        check("imem_addr_hold", imem_addr, pend_addr);
      end
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      update_model();
      choose_inputs();
    end
  endtask

  // Asserts rstn between clock edges and checks outputs react without an edge.
  task automatic do_reset();
    @(negedge clk); #3;
    rstn = 1'b0;
    mon_en = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_valid", valid, 1'b0);
    check("rst_instruction", instruction, NOP_W);
    check("rst_PC", PC, 32'h0);
    check("rst_halt", halt, 1'b0);
    @(negedge clk); #3;
    rstn = 1'b1;
    exp_q.delete();
    pending = 1'b0; live = 1'b0;
    next_addr = RESET_PC;
    mhalt = 1'b0;
    choose_inputs();
    mon_en = 1'b1;
  endtask

  // Monitor: compares head entry and pops the scoreboard on every accepted dequeue.
  initial begin
    entry_t e;
    logic exp_valid;
    forever begin
      @(negedge clk); #1;
      if (mon_en && rstn) begin
        exp_valid = (exp_q.size() != 0) && !mhalt;
        check("valid", valid, exp_valid);
        check("halt", halt, mhalt);
        if (exp_valid) begin
          check("head_PC", PC, exp_q[0].pc);
          check("head_instr", instruction, exp_q[0].instr);
        end else begin
          check("idle_instr", instruction, NOP_W);
          check("idle_PC", PC, 32'h0);
        end
        if (exp_valid && ready && !(npc_control && !mhalt)) begin
          e = exp_q.pop_front();
          if (e.instr == HALT_W) mhalt = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    int   guard;

    // In-order streaming with single-cycle memory
    do_reset();
    ack_pct = 100; ready_pct = 100; npc_pct = 0; junk_ack = 1'b0;
    choose_inputs();
    cycle(30);

    // Back-pressure: FIFO fills to DEPTH, then fetch stalls until decode drains
    do_reset();
    ready_pct = 0;
    choose_inputs();
    cycle(15);
    check("stall_req", imem_req, 1'b0);
    check("stall_valid", valid, 1'b1);
    ready_pct = 100;
    choose_inputs();
    cycle(15);

    // Randomized latency, back-pressure, stray acks and redirects
    ack_pct = 40; ready_pct = 60; npc_pct = 5; junk_ack = 1'b1;
    choose_inputs();
    cycle(3000);
    ack_pct = 70; ready_pct = 80; npc_pct = 20;
    choose_inputs();
    cycle(1000);

    // Halt at 0x10, redirect ignored while halted, reset restarts fetch
    halt_en = 1'b1;
    ack_pct = 100; ready_pct = 100; npc_pct = 0; junk_ack = 1'b0;
    do_reset();
    guard = 0;
    while (!mhalt && guard < 100) begin
      cycle(1);
      guard++;
    end
    found = mhalt;
    check("halt_reached", found, 1'b1);
    cycle(5);
    npc_pct = 100;
    choose_inputs();
    cycle(3);
    npc_pct = 0;
    choose_inputs();
    cycle(10);
    check("halted_req", imem_req, 1'b0);
    check("halted_flag", halt, 1'b1);
    check("halted_valid", valid, 1'b0);
    halt_en = 1'b0;
    do_reset();
    cycle(10);

    // Async reset with a request outstanding and three entries buffered
    do_reset();
    ready_pct = 0;
    choose_inputs();
    found = 1'b0;
    guard = 0;
    while (!found && guard < 50) begin
      cycle(1);
      if (exp_q.size() == 3 && imem_req) found = 1'b1;
      guard++;
    end
    check("async_setup", found, 1'b1);
    check("async_pre_valid", valid, 1'b1);
    do_reset();
    ready_pct = 100;
    choose_inputs();
    cycle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
